// File: rtl/face_detection_host_bridge_pkg.sv
// Shared face-detection constants and the host bridge state encoding.
package face_detection_host_bridge_pkg;

  localparam int DATA_WIDTH_16 = 16;
  localparam int DATA_WIDTH_12 = 12;
  localparam int FRAME_WIDTH   = 800;
  localparam int FRAME_HEIGHT  = 600;
  localparam int COORD_W       = 12;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_RDY,
    DRAIN_REQ,
    DRAIN_CAP,
    DRAIN_OUT,
    DONE,
    ERR
  } fdh_state_e;

endpackage

// File: rtl/face_detection_host_bridge_frame_coord_counter.sv
// Raster x/y coordinate counter that saturates on the last pixel of the frame
// and raises a sticky last flag there.
module frame_coord_counter #(
  parameter int FRAME_WIDTH  = 800,
  parameter int FRAME_HEIGHT = 600,
  parameter int COORD_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(FRAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(FRAME_HEIGHT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x    <= '0;
      y    <= '0;
      last <= 1'b0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      last <= 1'b0;
    end else if (advance && !last) begin
      if (x == X_MAX) begin
        // Final pixel holds the coordinates instead of wrapping past the frame.
        if (y == Y_MAX) begin
          last <= 1'b1;
        end else begin
          x <= '0;
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/face_detection_host_bridge.sv
// Host bridge: streams one frame of pixels into the detection core, then drains
// its result queue to a sink. Optional ready watchdog: FDH_READY_TIMEOUT_EN.
module face_detection_host_bridge #(
  parameter int FRAME_WIDTH    = face_detection_host_bridge_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT   = face_detection_host_bridge_pkg::FRAME_HEIGHT,
  parameter int DATA_WIDTH_16  = face_detection_host_bridge_pkg::DATA_WIDTH_16,
  parameter int DATA_WIDTH_12  = face_detection_host_bridge_pkg::DATA_WIDTH_12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_src_valid,
  input  logic [DATA_WIDTH_16-1:0] i_src_pixel,
  output logic                     o_src_ready,
  output logic                     o_recieve_pixel,
  output logic [DATA_WIDTH_16-1:0] o_pixel,
  input  logic                     i_fpga_ready_recieve_pixel,
  output logic                     o_send_result,
  input  logic [DATA_WIDTH_12-1:0] i_result_data,
  input  logic                     i_result_end,
  output logic                     o_res_valid,
  output logic [DATA_WIDTH_12-1:0] o_res_data,
  input  logic                     i_res_ready,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_error
);
  import face_detection_host_bridge_pkg::*;

  fdh_state_e         state, state_nxt;
  logic               first_pix;
  logic [COORD_W-1:0] x, y;
  logic               last_pix;
  logic [15:0]        res_cnt;
  logic               cnt_clr, cnt_adv;
  logic               tmo;

  frame_coord_counter #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .COORD_W     (COORD_W)
  ) u_coord (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .advance(cnt_adv),
    .x      (x),
    .y      (y),
    .last   (last_pix)
  );

`ifdef FDH_READY_TIMEOUT_EN
  logic [15:0] wdog;
  assign tmo = (wdog == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog    <= '0;
      o_error <= 1'b0;
    end else begin
      if (state == SEND)          wdog <= '0;
      else if (state == WAIT_RDY) wdog <= wdog + 1'b1;
      if (state == WAIT_RDY && !i_fpga_ready_recieve_pixel && tmo) o_error <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_adv   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (i_start) state_nxt = FETCH;
      end
      FETCH:     if (i_src_valid) state_nxt = SEND;
      SEND: begin
        cnt_adv   = 1'b1;
        state_nxt = WAIT_RDY;
      end
      // A ready pulse coincident with the SEND strobe is dropped by construction.
      WAIT_RDY: begin
        if (i_fpga_ready_recieve_pixel) state_nxt = last_pix ? DRAIN_REQ : FETCH;
        else if (tmo)                   state_nxt = ERR;
      end
      DRAIN_REQ: state_nxt = i_result_end ? DONE : DRAIN_CAP;
      DRAIN_CAP: state_nxt = DRAIN_OUT;
      DRAIN_OUT: if (i_res_ready) state_nxt = DRAIN_REQ;
      DONE:      state_nxt = IDLE;
      ERR:       state_nxt = ERR;
      default:   state_nxt = IDLE;
    endcase
  end

  assign o_src_ready     = (state == FETCH) && i_src_valid;
  assign o_recieve_pixel = (state == SEND);
  assign o_send_result   = (state == DRAIN_REQ) && !i_result_end;
  assign o_frame_done    = (state == DONE);
  assign o_busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_pixel     <= '0;
      o_res_data  <= '0;
      o_res_valid <= 1'b0;
      res_cnt     <= '0;
      first_pix   <= 1'b1;
    end else begin
      if (o_src_ready) o_pixel <= i_src_pixel;
      if (state == DRAIN_CAP) begin
        o_res_data  <= i_result_data;
        o_res_valid <= 1'b1;
      end else if (state == DRAIN_OUT && i_res_ready) begin
        o_res_valid <= 1'b0;
      end
      if (state == IDLE)                          res_cnt <= '0;
      else if (state == DRAIN_OUT && i_res_ready) res_cnt <= res_cnt + 1'b1;
      if (state == IDLE)      first_pix <= 1'b1;
      else if (state == SEND) first_pix <= 1'b0;
    end
  end

  a_first_at_origin: assert property (@(posedge clk) disable iff (!reset)
    first_pix |-> (x == '0 && y == '0));
  a_res_cnt_no_wrap: assert property (@(posedge clk) disable iff (!reset)
    (state == DRAIN_OUT && i_res_ready) |-> (res_cnt != '1));

endmodule

// File: tb/tb_face_detection_host_bridge.sv
// Directed bench for face_detection_host_bridge on a 4x3 frame with a small
// behavioural core/source/sink model.
module tb_face_detection_host_bridge;

  localparam int          NPIX     = 12;
  localparam logic [15:0] PIX_BASE = 16'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_src_valid = 1'b0;
  logic [15:0] i_src_pixel = '0;
  logic        o_src_ready, o_recieve_pixel;
  logic [15:0] o_pixel;
  logic        i_fpga_ready_recieve_pixel = 1'b0;
  logic        o_send_result;
  logic [11:0] i_result_data = '0;
  logic        i_result_end = 1'b1;
  logic        o_res_valid;
  logic [11:0] o_res_data;
  logic        i_res_ready = 1'b1;
  logic        o_busy, o_frame_done, o_error;

  always #5 clk = ~clk;

  face_detection_host_bridge #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .i_src_valid(i_src_valid), .i_src_pixel(i_src_pixel), .o_src_ready(o_src_ready),
    .o_recieve_pixel(o_recieve_pixel), .o_pixel(o_pixel),
    .i_fpga_ready_recieve_pixel(i_fpga_ready_recieve_pixel),
    .o_send_result(o_send_result), .i_result_data(i_result_data), .i_result_end(i_result_end),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .i_res_ready(i_res_ready),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_error(o_error)
  );

  int checks = 0, passed = 0;

  // model state
  int cyc = 0, src_idx, recv_cnt, ord_err, sr_cnt, done_cnt, rx_cnt, bad_ready;
  int hold_err, stall_seen, stall_left, rdy_cd, last_rdy_cyc, done_cyc, str_cyc;
  int q_len, q_idx;
  bit rdy_en = 1'b1, src_toggle = 1'b0, stall_en = 1'b0;
  logic [11:0] q [0:2];
  logic [11:0] rx_words [0:7];
  logic [11:0] next_data = '0;

  // Inputs are driven 1 time unit after the edge, outputs sampled 1 unit later.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      i_src_valid = src_toggle ? ~i_src_valid : 1'b1;
      i_src_pixel = PIX_BASE + 16'(src_idx);
      i_fpga_ready_recieve_pixel = 1'b0;
      if (rdy_cd > 0) begin
        rdy_cd--;
        if (rdy_cd == 0 && rdy_en) begin
          i_fpga_ready_recieve_pixel = 1'b1;
          last_rdy_cyc = cyc;
        end
      end
      i_result_data = next_data;
      i_result_end  = (q_idx >= q_len);
      i_res_ready   = !(stall_en && rx_cnt == 1 && stall_left > 0);
      #1;
      if (o_src_ready && !i_src_valid) bad_ready++;
      if (o_src_ready) src_idx++;
      if (o_recieve_pixel) begin
        if (o_pixel !== PIX_BASE + 16'(recv_cnt)) ord_err++;
        recv_cnt++;
        rdy_cd  = 2;
        str_cyc = cyc;
      end
      if (o_send_result) begin
        next_data = (q_idx < q_len) ? q[q_idx] : 12'hFFF;
        q_idx++;
        sr_cnt++;
      end
      if (o_res_valid) begin
        if (i_res_ready) begin
          if (rx_cnt < 8) rx_words[rx_cnt] = o_res_data;
          rx_cnt++;
        end else begin
          stall_seen++;
          if (o_res_data !== 12'h0B2) hold_err++;
          stall_left--;
        end
      end
      if (o_frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clr_stats();
    src_idx = 0; recv_cnt = 0; ord_err = 0; sr_cnt = 0; done_cnt = 0; rx_cnt = 0;
    bad_ready = 0; hold_err = 0; stall_seen = 0; stall_left = 0; rdy_cd = 0;
    last_rdy_cyc = -100; done_cyc = 0; str_cyc = 0; q_idx = 0; q_len = 0;
    rdy_en = 1'b1; src_toggle = 1'b0; stall_en = 1'b0;
    foreach (rx_words[i]) rx_words[i] = '0;
  endtask

  task automatic start_frame();
    @(posedge clk); #3; i_start = 1'b1;
    @(posedge clk); #3; i_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin @(posedge clk); #3; end
    repeat (4) begin @(posedge clk); #3; end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({o_busy, o_src_ready, o_recieve_pixel, o_send_result, o_res_valid, o_frame_done, o_error} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0000000",
        {o_busy, o_src_ready, o_recieve_pixel, o_send_result, o_res_valid, o_frame_done, o_error});
    else passed++;
    checks++;
    if ({o_pixel, o_res_data} !== 28'h0) $display("FAIL reset_data: pixel %h res %h want 0", o_pixel, o_res_data);
    else passed++;
    @(posedge clk); #3; reset = 1'b1;
  endtask

  task automatic test_frame_no_results();
    clr_stats();
    start_frame();
    wait_done();
    checks++; if (recv_cnt !== NPIX) $display("FAIL nores_strobes: got %0d want %0d", recv_cnt, NPIX); else passed++;
    checks++; if (ord_err !== 0) $display("FAIL nores_order: got %0d errors want 0", ord_err); else passed++;
    checks++; if (sr_cnt !== 0) $display("FAIL nores_send_result: got %0d want 0", sr_cnt); else passed++;
    checks++; if (done_cnt !== 1) $display("FAIL nores_done_count: got %0d want 1", done_cnt); else passed++;
    checks++;
    if (done_cyc - last_rdy_cyc !== 2) $display("FAIL nores_done_latency: got %0d want 2", done_cyc - last_rdy_cyc);
    else passed++;
    checks++; if (o_busy !== 1'b0) $display("FAIL nores_idle: busy %b want 0", o_busy); else passed++;
  endtask

  task automatic test_results(input bit stall);
    clr_stats();
    q[0] = 12'h0A1; q[1] = 12'h0B2; q[2] = 12'h0C3; q_len = 3;
    stall_en = stall; stall_left = 5;
    start_frame();
    wait_done();
    checks++; if (sr_cnt !== 3) $display("FAIL res_send_result(stall=%0d): got %0d want 3", stall, sr_cnt); else passed++;
    checks++; if (rx_cnt !== 3) $display("FAIL res_words(stall=%0d): got %0d want 3", stall, rx_cnt); else passed++;
    checks++;
    if ({rx_words[0], rx_words[1], rx_words[2]} !== 36'h0A1_0B2_0C3)
      $display("FAIL res_data(stall=%0d): got %h %h %h want 0a1 0b2 0c3", stall, rx_words[0], rx_words[1], rx_words[2]);
    else passed++;
    checks++; if (done_cnt !== 1) $display("FAIL res_done(stall=%0d): got %0d want 1", stall, done_cnt); else passed++;
    if (stall) begin
      checks++; if (stall_seen !== 5) $display("FAIL stall_cycles: got %0d want 5", stall_seen); else passed++;
      checks++; if (hold_err !== 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_err); else passed++;
    end
  endtask

  task automatic test_src_toggle();
    clr_stats();
    src_toggle = 1'b1;
    start_frame();
    for (int i = 0; i < 200 && recv_cnt < 3; i++) begin @(posedge clk); #3; end
    start_frame();
    wait_done();
    checks++; if (bad_ready !== 0) $display("FAIL tog_ready_no_valid: got %0d want 0", bad_ready); else passed++;
    checks++; if (ord_err !== 0) $display("FAIL tog_order: got %0d errors want 0", ord_err); else passed++;
    checks++; if (recv_cnt !== NPIX) $display("FAIL tog_strobes: got %0d want %0d", recv_cnt, NPIX); else passed++;
    checks++; if (src_idx !== NPIX) $display("FAIL tog_consumed: got %0d want %0d", src_idx, NPIX); else passed++;
    checks++; if (done_cnt !== 1) $display("FAIL tog_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_reset_midframe();
    clr_stats();
    start_frame();
    for (int i = 0; i < 200 && recv_cnt < 7; i++) begin @(posedge clk); #3; end
    @(posedge clk); #3;
    checks++; if (o_busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", o_busy); else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_recieve_pixel, o_send_result, o_res_valid, o_frame_done, o_error, o_pixel} !== 22'h0)
      $display("FAIL mid_reset_outputs: busy %b strobe %b pixel %h want 0", o_busy, o_recieve_pixel, o_pixel);
    else passed++;
    @(posedge clk); #3; reset = 1'b1;
    clr_stats();
    start_frame();
    wait_done();
    checks++; if (ord_err !== 0) $display("FAIL mid_restart_order: got %0d errors want 0", ord_err); else passed++;
    checks++; if (recv_cnt !== NPIX) $display("FAIL mid_restart_strobes: got %0d want %0d", recv_cnt, NPIX); else passed++;
  endtask

`ifdef FDH_READY_TIMEOUT_EN
  task automatic test_timeout();
    int err_cyc;
    clr_stats();
    rdy_en = 1'b0;
    err_cyc = -1;
    start_frame();
    for (int i = 0; i < 100 && err_cyc < 0; i++) begin
      @(posedge clk); #3;
      if (o_error === 1'b1) err_cyc = cyc;
    end
    checks++; if (err_cyc - str_cyc !== 17) $display("FAIL tmo_latency: got %0d want 17", err_cyc - str_cyc); else passed++;
    start_frame();
    repeat (10) begin @(posedge clk); #3; end
    checks++; if (recv_cnt !== 1) $display("FAIL tmo_no_strobes: got %0d want 1", recv_cnt); else passed++;
    checks++; if ({o_busy, o_error} !== 2'b11) $display("FAIL tmo_stuck: got %b want 11", {o_busy, o_error}); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (o_error !== 1'b0) $display("FAIL tmo_reset_clear: got %b want 0", o_error); else passed++;
    @(posedge clk); #3; reset = 1'b1;
  endtask
`endif

  initial begin
    clr_stats();
    test_reset();
    test_frame_no_results();
    test_results(1'b0);
    test_results(1'b1);
    test_src_toggle();
    test_reset_midframe();
`ifdef FDH_READY_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
